// File: rtl/mmio_bridge.sv
// CPU-side initiator for the device bus: decodes the device window, drives DEV0/DEV1
// strobes, returns registered load data and captures faults and interrupt lines.
module mmio_bridge #(
   parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
   parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
   parameter logic [31:0] BR_BASE   = 32'h0000_7F20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wd,
   input  logic        cpu_we,
   input  logic        cpu_re,
   input  logic [1:0]  cpu_width,
   input  logic        cpu_sext,
   output logic [31:0] cpu_rd,
   output logic        cpu_rvalid,
   output logic        cpu_err,
   output logic [5:0]  hwint,
   output logic [31:0] dev_addr,
   output logic [31:0] dev_wd,
   output logic [3:0]  dev_be,
   output logic        dev0_we,
   output logic        dev1_we,
   input  logic [31:0] dev0_rd,
   input  logic [31:0] dev1_rd,
   input  logic        dev0_irq,
   input  logic        dev1_irq,
   input  logic [3:0]  ext_irq
);

   logic        hit0, hit1, hitbr, req, misalign, fault, ok;
   logic [3:0]  be_raw;
   logic [31:0] rd_sel;
   logic        status;
   logic [31:0] badaddr;
   logic [31:0] word_p1;
   logic [1:0]  lane_p1;
   logic [1:0]  width_p1;
   logic        sext_p1;
   logic        vld_p1;
   logic        err_p1;
   logic [5:0]  hwint_p1;

   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [1:0] width, input logic sext);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (width)
         2'b10:   extract = {{24{sext & b[7]}}, b};
         2'b01:   extract = {{16{sext & h[15]}}, h};
         default: extract = word;
      endcase
   endfunction

   assign hit0  = (cpu_addr >= DEV0_BASE) && (cpu_addr < DEV0_BASE + 32'd12);
   assign hit1  = (cpu_addr >= DEV1_BASE) && (cpu_addr < DEV1_BASE + 32'd12);
   assign hitbr = (cpu_addr >= BR_BASE)   && (cpu_addr < BR_BASE + 32'd8);
   assign req   = cpu_we | cpu_re;

   assign misalign = ((cpu_width == 2'b00) && (cpu_addr[1:0] != 2'b00)) ||
                     ((cpu_width == 2'b01) && cpu_addr[0]);

   // Bridge registers are word-only; devices accept sub-word accesses.
   assign fault = req && (!(hit0 || hit1 || hitbr) || misalign || (cpu_width == 2'b11) ||
                          (cpu_we && cpu_re) || (hitbr && (cpu_width != 2'b00)));
   assign ok    = req && !fault;

   always_comb begin
      be_raw = 4'b0000;
      dev_wd = cpu_wd;
      case (cpu_width)
         2'b00: be_raw = 4'b1111;
         2'b01: begin
            be_raw = cpu_addr[1] ? 4'b1100 : 4'b0011;
            dev_wd = {2{cpu_wd[15:0]}};
         end
         2'b10: begin
            be_raw = 4'b0001 << cpu_addr[1:0];
            dev_wd = {4{cpu_wd[7:0]}};
         end
         default: be_raw = 4'b0000;
      endcase
   end

   assign dev_addr = cpu_addr;
   assign dev_be   = (ok && cpu_we) ? be_raw : 4'b0000;
   assign dev0_we  = !reset && ok && cpu_we && hit0;
   assign dev1_we  = !reset && ok && cpu_we && hit1;

   always_comb begin
      rd_sel = 32'h0;
      if (hit0)             rd_sel = dev0_rd;
      else if (hit1)        rd_sel = dev1_rd;
      else if (cpu_addr[2]) rd_sel = badaddr;
      else                  rd_sel = {31'b0, status};
   end

   // Bridge state: a fault in the same cycle as a STATUS clear leaves STATUS set.
   always_ff @(posedge clk) begin
      if (reset) begin
         status  <= 1'b0;
         badaddr <= 32'h0;
      end else if (fault) begin
         status  <= 1'b1;
         badaddr <= cpu_addr;
      end else if (ok && cpu_we && hitbr && !cpu_addr[2] && cpu_wd[0]) begin
         status  <= 1'b0;
      end
   end

   // Request -> response stage boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_p1  <= 32'h0;
         lane_p1  <= 2'b00;
         width_p1 <= 2'b00;
         sext_p1  <= 1'b0;
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
         hwint_p1 <= 6'b0;
      end else begin
         vld_p1   <= ok && cpu_re;
         err_p1   <= fault;
         hwint_p1 <= {ext_irq, dev1_irq, dev0_irq};
         if (ok && cpu_re) begin
            word_p1  <= rd_sel;
            lane_p1  <= cpu_addr[1:0];
            width_p1 <= cpu_width;
            sext_p1  <= cpu_sext;
         end
      end
   end

   assign cpu_rd     = extract(word_p1, lane_p1, width_p1, sext_p1);
   assign cpu_rvalid = vld_p1 && !reset;
   assign cpu_err    = err_p1 && !reset;
   assign hwint      = hwint_p1;

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

CPU-side initiator for the memory-mapped device bus. Decodes CPU load/store requests in the device window and routes them to timer/counter devices DEV0 and DEV1. Generates byte enables and replicated write data, and returns registered, extracted read data. Also captures bus errors, and registers device and external interrupt lines into the CPU's hardware-interrupt vector.

## Interface
Parameters:
- DEV0_BASE, 32'h0000_7F00, base of device 0 (three word registers, offsets 0/4/8)
- DEV1_BASE, 32'h0000_7F10, base of device 1 (same layout)
- BR_BASE, 32'h0000_7F20, base of bridge-internal registers (STATUS at +0, BADADDR at +4)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_addr  in  32  byte address of request
- cpu_wd  in  32  store data, right-aligned
- cpu_we  in  1  store request, one cycle
- cpu_re  in  1  load request, one cycle
- cpu_width  in  2  00 word, 01 half, 10 byte, 11 reserved
- cpu_sext  in  1  sign-extend sub-word loads
- cpu_rd  out  32  load result, extracted and extended
- cpu_rvalid  out  1  load result valid, one-cycle pulse
- cpu_err  out  1  request faulted, one-cycle pulse
- hwint  out  6  {ext_irq[3:0], dev1_irq, dev0_irq}, registered
- dev_addr  out  32  equals cpu_addr
- dev_wd  out  32  replicated store data
- dev_be  out  4  byte enables
- dev0_we, dev1_we  out  1  per-device write strobe
- dev0_rd, dev1_rd  in  32  device read data, combinational from dev_addr
- dev0_irq, dev1_irq  in  1  level interrupts
- ext_irq  in  4  external level interrupts

## Operation
- Decode: DEV0 hit when DEV0_BASE ≤ addr < DEV0_BASE+12. DEV1 hit is the same relative to DEV1_BASE. BR hit when BR_BASE ≤ addr < BR_BASE+8. Any other address is unmapped.
- Faults, checked in cycle of request:
  - unmapped address
  - misaligned access: word with addr[1:0]≠0, or half with addr[0]≠0
  - cpu_width==11
  - cpu_we and cpu_re both high
  - sub-word write to DEV0/DEV1 is legal; sub-word access to BR is a fault.
- A faulting request asserts no dev*_we and writes no BR register. It sets STATUS[0] (sticky), loads BADADDR←cpu_addr (every fault overwrites), and pulses cpu_err in the next cycle. A faulting load does not pulse cpu_rvalid.
- Byte enables:
  - word: 1111
  - half: addr[1] ? 1100 : 0011
  - byte: 0001<<addr[1:0]
  - dev_be is 0000 when no valid store.
- dev_wd:
  - word: cpu_wd
  - half: {2{cpu_wd[15:0]}}
  - byte: {4{cpu_wd[7:0]}}
- Store: dev0_we/dev1_we is combinational, high only in the request cycle for a valid hit. A BR store to STATUS with wd[0]=1 clears STATUS[0]. BADADDR is read-only; storing to it is ignored without a fault.
- Load:
  - In the request cycle, select the word: dev0_rd, dev1_rd, STATUS ({31'b0,err}), or BADADDR.
  - Register the word, addr[1:0], width, and sext.
  - In the next cycle, output the selected field on cpu_rd:
    - byte: lane addr[1:0]
    - half: lane addr[1]
  - Zero-extend or sign-extend per cpu_sext.
- hwint: registered every cycle from the inputs; no masking (masking belongs to CP0).

## Timing
- Reset values:
  - cpu_rd=0, cpu_rvalid=0, cpu_err=0, hwint=0
  - STATUS=0, BADADDR=0
  - dev*_we=0 while reset is high, regardless of cpu_we.
- Store latency: device samples at the end of the request cycle N. No response pulse is generated for a successful store.
- Load latency: 1. Request in cycle N gives cpu_rvalid and cpu_rd in N+1. cpu_rd holds its value until the next load completes.
- Error latency: 1. cpu_err is high in N+1 only.
- Back-to-back requests: one per cycle, no stall.
  - A load in N+1 reads state written by a store in N.
  - A BR store clearing STATUS in N and a fault in N: the fault wins, STATUS[0]=1.
- hwint lags its inputs by exactly one cycle.
- Reset mid-operation: a pending rvalid or err pulse is dropped and registers clear.

## Test plan
- Word store to 0x7F04 with cpu_wd=0x0000_0010 → dev0_we=1, dev1_we=0, dev_be=1111, dev_wd=0x10 in the same cycle. Word load from 0x7F04 with dev0_rd=0x10 → rvalid at N+1, cpu_rd=0x10.
- Byte store to 0x7F13 with cpu_wd=0xAB → dev1_we=1, dev_be=1000, dev_wd=0xABABABAB. Half load from 0x7F12 with dev1_rd=0x8001_0000 and sext=1 → cpu_rd=0xFFFF_8001; with sext=0 → 0x0000_8001.
- Word load from 0x7F02 (misaligned) → no rvalid, cpu_err at N+1. Load from 0x7F20 → 0x1. Load from 0x7F24 → 0x7F02.
- Store 0x1 to 0x7F20 → STATUS=0. Same cycle as a fault in a further test (separate request streams not possible), so instead: store to 0x7F0C (unmapped) → err, no dev*_we, STATUS back to 1.
- dev0_irq rises at cycle N and ext_irq=0101 → hwint=010101 at N+1. dev0_irq falls → hwint[0]=0 one cycle later.
- Assert reset the cycle after a load request → cpu_rvalid stays 0, cpu_rd=0, STATUS=0, hwint=0.
